// File: rtl/soc_boot_loader_pkg.sv
// Shared widths and FSM state encoding for the boot-image loader.
// No logic; types and constants only.
// Imported by the loader top and its bench.
package soc_boot_loader_pkg;

    localparam int WB_ADDR_W = 24;   // Wishbone word-address width
    localparam int RW        = 16;   // Wishbone data width (one packed word)

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_DAT_LO = 4'd3,
        ST_DAT_HI = 4'd4,
        ST_WRITE  = 4'd5,
        ST_CSUM   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } state_t;

endpackage

// File: rtl/soc_boot_loader.sv
// Boot-image writer: framed byte stream -> 16-bit LE words -> Wishbone single writes, XOR trailer check.
// Latency: bus strobe rises the cycle after the high data byte is accepted; 1 byte/cycle in rx states.
// Backpressure: rx_ready is low outside the byte-receiving states; a write holds until wb_ack/wb_err.
module soc_boot_loader
    import soc_boot_loader_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                   MAX_WORDS = 2048
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [WB_ADDR_W-1:0] wb_adr,
    output logic [RW-1:0]        wb_o_dat,
    output logic [1:0]           wb_sel,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [15:0]          o_words
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  lo_byte;
    logic [7:0]  csum;
    logic [15:0] word_cnt;     // doubles as the write index and the reported word count
    logic        rx_fire;
    logic [15:0] len_rx;
    logic [15:0] word_cnt_inc;

    assign rx_fire      = rx_valid & rx_ready;
    assign len_rx       = {rx_data, len_lo};
    assign word_cnt_inc = word_cnt + 16'd1;
    assign o_words      = word_cnt;

    // Byte acceptance and status flags are pure decodes of the current state.
    always_comb begin
        rx_ready = 1'b0;
        o_busy   = 1'b1;
        o_done   = 1'b0;
        o_error  = 1'b0;
        case (state)
            ST_LEN_LO, ST_LEN_HI, ST_DAT_LO, ST_DAT_HI, ST_CSUM: rx_ready = 1'b1;
            ST_IDLE: o_busy = 1'b0;
            ST_ERR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; bus error outranks ack when both arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR: if (i_start) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (rx_fire) state_nxt = ST_LEN_HI;
            ST_LEN_HI: begin
                if (rx_fire) begin
                    if (len_rx == 16'd0)     state_nxt = ST_CSUM;
                    else if (len_rx > MAX_N) state_nxt = ST_ERR;
                    else                     state_nxt = ST_DAT_LO;
                end
            end
            ST_DAT_LO: if (rx_fire) state_nxt = ST_DAT_HI;
            ST_DAT_HI: if (rx_fire) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (wb_err)      state_nxt = ST_ERR;
                else if (wb_ack) state_nxt = (word_cnt_inc == len) ? ST_CSUM : ST_DAT_LO;
            end
            ST_CSUM: if (rx_fire) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered Wishbone master; the write is staged on the high-byte accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_lo   <= '0;
            len      <= '0;
            lo_byte  <= '0;
            csum     <= '0;
            word_cnt <= '0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= 2'b00;
            wb_adr   <= BASE_ADDR;
            wb_o_dat <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (i_start) begin
                        csum     <= '0;
                        word_cnt <= '0;
                    end
                end
                ST_LEN_LO: if (rx_fire) len_lo <= rx_data;
                ST_LEN_HI: if (rx_fire) len <= len_rx;
                ST_DAT_LO: begin
                    if (rx_fire) begin
                        lo_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                    end
                end
                ST_DAT_HI: begin
                    if (rx_fire) begin
                        csum     <= csum ^ rx_data;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_sel   <= 2'b11;
                        wb_adr   <= BASE_ADDR + WB_ADDR_W'(word_cnt);
                        wb_o_dat <= {rx_data, lo_byte};
                    end
                end
                ST_WRITE: begin
                    if (wb_err || wb_ack) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        wb_sel <= 2'b00;
                        if (!wb_err) word_cnt <= word_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_boot_loader.sv
module tb_soc_boot_loader;
    import soc_boot_loader_pkg::*;

    localparam logic [WB_ADDR_W-1:0] BASE = 24'hffffff;
    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int                   kind;
        logic [WB_ADDR_W-1:0] adr;
        logic [RW-1:0]        dat;
        int                   cycles;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 rx_valid = 1'b0;
    logic                 rx_ready;
    logic                 wb_cyc, wb_stb, wb_we;
    logic [WB_ADDR_W-1:0] wb_adr;
    logic [RW-1:0]        wb_o_dat;
    logic [1:0]           wb_sel;
    logic                 wb_ack = 1'b0;
    logic                 wb_err = 1'b0;
    logic                 o_busy, o_done, o_error;
    logic [15:0]          o_words;

    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];
    int  ack_delay = 0;
    bit  err_mode = 1'b0;
    bit  rand_gap = 1'b0;

    soc_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(2048)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_words(o_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    task automatic push(input int kind, input logic [WB_ADDR_W-1:0] adr,
                        input logic [RW-1:0] dat, input int cycles);
        ev_t e;
        e.kind = kind; e.adr = adr; e.dat = dat; e.cycles = cycles;
        exp_q.push_back(e);
    endtask

    // Wishbone slave: answers each strobe after ack_delay extra cycles.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_stb) begin
                if (cnt == ack_delay) begin
                    if (err_mode) wb_err = 1'b1;
                    else          wb_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each acked write, done pulse and error entry.
    initial begin
        bit                   in_wr = 1'b0;
        bit                   wr_bad = 1'b0;
        bit                   err_prev = 1'b0;
        int                   wr_cyc = 0;
        logic [WB_ADDR_W-1:0] wr_adr = '0;
        logic [RW-1:0]        wr_dat = '0;
        ev_t                  e;
        forever begin
            @(negedge clk);
            #1;
            if (wb_stb) begin
                if (!in_wr) begin
                    in_wr = 1'b1; wr_cyc = 1; wr_adr = wb_adr; wr_dat = wb_o_dat; wr_bad = 1'b0;
                end else begin
                    wr_cyc++;
                    if (wb_adr !== wr_adr || wb_o_dat !== wr_dat) wr_bad = 1'b1;
                end
                if (rx_ready !== 1'b0 || wb_cyc !== 1'b1 || wb_we !== 1'b1 || wb_sel !== 2'b11)
                    wr_bad = 1'b1;
                if (wb_ack && !wb_err) begin
                    if (exp_q.size() == 0) fail_now("unexpected_write");
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_kind", 32'(EV_WR), 32'(e.kind));
                        chk("wr_adr", 32'(wr_adr), 32'(e.adr));
                        chk("wr_dat", 32'(wr_dat), 32'(e.dat));
                        chk("wr_stb_cycles", 32'(wr_cyc), 32'(e.cycles));
                        chk("wr_bus_hold", 32'(wr_bad), 32'd0);
                    end
                end
                if (wb_ack || wb_err) in_wr = 1'b0;
            end else begin
                in_wr = 1'b0;
            end
            if (o_done === 1'b1) begin
                if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 32'(EV_DONE), 32'(e.kind));
                end
            end
            if (o_error === 1'b1 && !err_prev) begin
                if (exp_q.size() == 0) fail_now("unexpected_error");
                else begin
                    e = exp_q.pop_front();
                    chk("err_kind", 32'(EV_ERR), 32'(e.kind));
                end
            end
            err_prev = (o_error === 1'b1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (rand_gap) cycles($urandom_range(0, 2));
        rx_data  = b;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_ready) break;
            n++;
            if (n > 100) begin fail_now("rx_accept"); break; end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk); #2;
            if (!o_busy) break;
            n++;
            if (n > 300) begin fail_now("wait_idle"); break; end
        end
        cycles(1);
    endtask

    // Good frame: two words, trailer = 34^12^78^56 = 08.
    task automatic send_frame(input logic [7:0] trailer);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78); send_byte(8'h56);
        send_byte(trailer);
    endtask

    initial begin
        // Reset state.
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("rst_we_sel", {29'd0, wb_we, wb_sel}, 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'(BASE));
        chk("rst_dat", 32'(wb_o_dat), 32'd0);
        chk("rst_flags", {28'd0, rx_ready, o_busy, o_done, o_error}, 32'd0);
        chk("rst_words", 32'(o_words), 32'd0);
        cycles(1);

        // Zero-wait frame; BASE=ffffff so the second word wraps to 0.
        ack_delay = 0;
        pulse_start();
        push(EV_WR, 24'hffffff, 16'h1234, 1);
        push(EV_WR, 24'h000000, 16'h5678, 1);
        push(EV_DONE, '0, '0, 0);
        send_frame(8'h08);
        wait_idle();
        chk("a_words", 32'(o_words), 32'd2);
        chk("a_error", 32'(o_error), 32'd0);

        // Slow slave: strobe held 6 sampled cycles with stable address/data.
        ack_delay = 5;
        pulse_start();
        push(EV_WR, 24'hffffff, 16'h1234, 6);
        push(EV_WR, 24'h000000, 16'h5678, 6);
        push(EV_DONE, '0, '0, 0);
        send_frame(8'h08);
        wait_idle();
        chk("b_words", 32'(o_words), 32'd2);

        // Bad trailer: words still written, then error without done.
        ack_delay = 0;
        pulse_start();
        push(EV_WR, 24'hffffff, 16'h1234, 1);
        push(EV_WR, 24'h000000, 16'h5678, 1);
        push(EV_ERR, '0, '0, 0);
        send_frame(8'h4D);
        wait_idle();
        chk("c_error", 32'(o_error), 32'd1);
        chk("c_words", 32'(o_words), 32'd2);
        pulse_start();
        @(negedge clk);
        chk("c_restart_ready", 32'(rx_ready), 32'd1);
        chk("c_restart_flags", {30'd0, o_busy, o_error}, 32'd2);
        chk("c_restart_words", 32'(o_words), 32'd0);
        cycles(1);

        // Empty frame straight from LEN_LO: no bus cycle, trailer 00.
        push(EV_DONE, '0, '0, 0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle();
        chk("d_words", 32'(o_words), 32'd0);
        chk("d_error", 32'(o_error), 32'd0);

        // Oversize length 0x0801 -> error after the high length byte.
        pulse_start();
        push(EV_ERR, '0, '0, 0);
        send_byte(8'h01); send_byte(8'h08);
        wait_idle();
        chk("e_error", 32'(o_error), 32'd1);
        chk("e_cyc", 32'(wb_cyc), 32'd0);

        // Bus error on the first write.
        err_mode = 1'b1;
        pulse_start();
        push(EV_ERR, '0, '0, 0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        wait_idle();
        chk("f_error", 32'(o_error), 32'd1);
        chk("f_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("f_words", 32'(o_words), 32'd0);
        err_mode = 1'b0;

        // Reset while a write is outstanding.
        ack_delay = 20;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        begin
            int n = 0;
            forever begin
                @(negedge clk);
                if (wb_stb) break;
                n++;
                if (n > 20) begin fail_now("g_stb_wait"); break; end
            end
        end
        chk("g_stb_before_rst", 32'(wb_stb), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("g_rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("g_rst_we_sel", {29'd0, wb_we, wb_sel}, 32'd0);
        chk("g_rst_flags", {28'd0, rx_ready, o_busy, o_done, o_error}, 32'd0);
        chk("g_rst_words_dat", {o_words, wb_o_dat}, 32'd0);
        chk("g_rst_adr", 32'(wb_adr), 32'(BASE));
        rst = 1'b0;
        cycles(1);

        // Irregular byte arrival, wrap-around and word order.
        ack_delay = 2;
        rand_gap = 1'b1;
        pulse_start();
        push(EV_WR, 24'hffffff, 16'h1234, 3);
        push(EV_WR, 24'h000000, 16'h5678, 3);
        push(EV_DONE, '0, '0, 0);
        send_frame(8'h08);
        wait_idle();
        chk("h_words", 32'(o_words), 32'd2);
        rand_gap = 1'b0;

        cycles(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
